// File: rtl/flag_register.sv
// Z/N/C condition-code register with branch consume and a LIFO of snapshots for interrupt save/restore.
// Latency 1 cycle (all outputs registered); en=0 stalls every piece of state.
module flag_register #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             alu_valid,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carry,
    input  logic [2:0]       flag_we,
    input  logic             setc,
    input  logic             clrc,
    input  logic             br_valid,
    input  logic             br_taken,
    input  logic [2:0]       branch,
    input  logic             save,
    input  logic             restore,
    output logic             z,
    output logic             n,
    output logic             c,
    output logic             stack_empty,
    output logic             stack_full,
    output logic             stack_err
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    localparam logic [2:0] BR_JZ = 3'b101;
    localparam logic [2:0] BR_JN = 3'b110;
    localparam logic [2:0] BR_JC = 3'b111;

    // Flag vectors and stack entries are packed as {c, n, z}.
    logic [2:0]    flags_q, flags_d;
    logic [2:0]    upd_flags;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic [2:0]    stack_q [DEPTH];

    logic          empty, full;
    logic          push, pop;
    logic          save_only, restore_only;
    logic [IW-1:0] push_idx, top_idx;

    assign empty        = (cnt_q == '0);
    assign full         = (cnt_q == CW'(DEPTH));
    assign push_idx     = IW'(cnt_q);
    assign top_idx      = IW'(cnt_q - CW'(1));
    assign save_only    = save && !restore;
    assign restore_only = restore && !save;

    always_comb begin
        upd_flags = flags_q;
        flags_d   = flags_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        push      = 1'b0;
        pop       = 1'b0;

        if (en) begin
            if (br_valid && br_taken) begin
                case (branch)
                    BR_JZ:   upd_flags[0] = 1'b0;
                    BR_JN:   upd_flags[1] = 1'b0;
                    BR_JC:   upd_flags[2] = 1'b0;
                    default: ;
                endcase
            end

            // ALU write follows consume so a same-cycle write of a consumed flag wins.
            if (alu_valid) begin
                if (flag_we[0]) upd_flags[0] = (alu_result == '0);
                if (flag_we[1]) upd_flags[1] = alu_result[WIDTH-1];
                if (flag_we[2]) upd_flags[2] = alu_carry;
            end

            if (setc && !clrc) begin
                upd_flags[2] = 1'b1;
            end else if (clrc && !setc) begin
                upd_flags[2] = 1'b0;
            end

            pop  = restore_only && !empty;
            push = save_only && !full;

            if ((save && restore) || (restore_only && empty) || (save_only && full)) begin
                err_d = 1'b1;
            end

            flags_d = pop ? stack_q[top_idx] : upd_flags;

            if (pop) begin
                cnt_d = cnt_q - CW'(1);
            end else if (push) begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flags_q <= 3'b000;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            flags_q <= flags_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Snapshot storage needs no reset; the count alone defines which entries are live.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            stack_q[push_idx] <= flags_q;
        end
    end

    assign z           = flags_q[0];
    assign n           = flags_q[1];
    assign c           = flags_q[2];
    assign stack_empty = empty;
    assign stack_full  = full;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_flag_register.sv
module tb_flag_register;

    localparam int W = 16;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst, en, alu_valid, alu_carry, setc, clrc;
    logic         br_valid, br_taken, save, restore;
    logic [W-1:0] alu_result;
    logic [2:0]   flag_we, branch;
    logic         z, n, c, stack_empty, stack_full, stack_err;

    int vectors = 0;
    int errors  = 0;

    // Reference state: flags as plain bits, snapshots in a queue (back = top).
    logic       mz, mn, mc, merr;
    logic [2:0] mstk[$];

    flag_register #(.WIDTH(W), .DEPTH(D)) dut (
        .clk(clk), .rst(rst), .en(en),
        .alu_valid(alu_valid), .alu_result(alu_result), .alu_carry(alu_carry),
        .flag_we(flag_we), .setc(setc), .clrc(clrc),
        .br_valid(br_valid), .br_taken(br_taken), .branch(branch),
        .save(save), .restore(restore),
        .z(z), .n(n), .c(c),
        .stack_empty(stack_empty), .stack_full(stack_full), .stack_err(stack_err)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] act_vec();
        return {z, n, c, stack_empty, stack_full, stack_err};
    endfunction

    function automatic logic [5:0] exp_vec();
        return {mz, mn, mc, (mstk.size() == 0), (mstk.size() == D), merr};
    endfunction

    task automatic idle();
        rst = 0; en = 1; alu_valid = 0; alu_result = '0; alu_carry = 0; flag_we = 3'b000;
        setc = 0; clrc = 0; br_valid = 0; br_taken = 0; branch = 3'b000; save = 0; restore = 0;
    endtask

    task automatic alu(input logic [W-1:0] r, input logic cy, input logic [2:0] we);
        alu_valid = 1; alu_result = r; alu_carry = cy; flag_we = we;
    endtask

    // Applies the inputs present at the edge to the reference model.
    task automatic model_step();
        logic nz, nn, nc;
        if (rst) begin
            mz = 0; mn = 0; mc = 0; merr = 0; mstk.delete();
            return;
        end
        if (!en) return;
        nz = mz; nn = mn; nc = mc;
        if (br_valid && br_taken) begin
            if (branch == 3'b101) nz = 0;
            if (branch == 3'b110) nn = 0;
            if (branch == 3'b111) nc = 0;
        end
        if (alu_valid) begin
            if (flag_we[0]) nz = (alu_result == 0);
            if (flag_we[1]) nn = alu_result[W-1];
            if (flag_we[2]) nc = alu_carry;
        end
        if (setc && !clrc) nc = 1;
        if (clrc && !setc) nc = 0;
        if (save && restore) begin
            merr = 1;
        end else if (restore) begin
            if (mstk.size() == 0) merr = 1;
            else {nc, nn, nz} = mstk.pop_back();
        end else if (save) begin
            if (mstk.size() == D) merr = 1;
            else mstk.push_back({mc, mn, mz});
        end
        mz = nz; mn = nn; mc = nc;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic test_reset();
        idle(); rst = 1; cycle(); cycle(); idle();
        vectors++;
        if (act_vec() !== 6'b000100) begin
            errors++; $display("FAIL reset: got znc_E_F_err=%b exp=%b", act_vec(), 6'b000100);
        end
    endtask

    task automatic test_alu_flags();
        logic [2:0] exp_flags [2] = '{3'b101, 3'b010};
        logic [W-1:0] res [2] = '{16'h0000, 16'h8001};
        logic cys [2] = '{1'b1, 1'b0};
        for (int i = 0; i < 2; i++) begin
            idle(); alu(res[i], cys[i], 3'b111); cycle(); idle();
            vectors++;
            if ({z, n, c} !== exp_flags[i] || act_vec() !== exp_vec()) begin
                errors++; $display("FAIL alu_flags[%0d]: got znc=%b exp=%b", i, {z, n, c}, exp_flags[i]);
            end
        end
    endtask

    task automatic test_masked_carry();
        idle(); alu(16'h0000, 1'b0, 3'b001); cycle();
        idle(); alu(16'h8000, 1'b1, 3'b110); cycle();
        idle(); alu(16'h0005, 1'b0, 3'b010); cycle(); idle();
        vectors++;
        if ({z, n, c} !== 3'b101 || act_vec() !== exp_vec()) begin
            errors++; $display("FAIL masked_write: got znc=%b exp=101", {z, n, c});
        end
        clrc = 1; cycle(); idle();
        vectors++;
        if ({z, n, c} !== 3'b100) begin
            errors++; $display("FAIL clrc: got znc=%b exp=100", {z, n, c});
        end
        setc = 1; clrc = 1; cycle(); idle();
        vectors++;
        if ({z, n, c} !== 3'b100 || act_vec() !== exp_vec()) begin
            errors++; $display("FAIL setc_clrc: got znc=%b exp=100", {z, n, c});
        end
    endtask

    task automatic test_consume();
        br_valid = 1; br_taken = 1; branch = 3'b101; cycle(); idle();
        vectors++;
        if ({z, n, c} !== 3'b000) begin
            errors++; $display("FAIL consume_jz: got znc=%b exp=000", {z, n, c});
        end
        alu(16'h0000, 1'b0, 3'b001); cycle(); idle();
        br_valid = 1; br_taken = 1; branch = 3'b100; cycle(); idle();
        vectors++;
        if ({z, n, c} !== 3'b100) begin
            errors++; $display("FAIL consume_jmp: got znc=%b exp=100", {z, n, c});
        end
        br_valid = 1; br_taken = 1; branch = 3'b101; alu(16'h0000, 1'b0, 3'b001); cycle(); idle();
        vectors++;
        if ({z, n, c} !== 3'b100 || act_vec() !== exp_vec()) begin
            errors++; $display("FAIL consume_vs_alu: got znc=%b exp=100", {z, n, c});
        end
    endtask

    task automatic test_nesting();
        logic [2:0] exp_cnz [4] = '{3'b100, 3'b010, 3'b001, 3'b001};
        idle(); rst = 1; cycle(); idle();
        alu(16'h0000, 1'b0, 3'b111); cycle(); idle();
        save = 1; alu(16'h8000, 1'b0, 3'b111); cycle(); idle();
        save = 1; alu(16'h0001, 1'b1, 3'b111); cycle(); idle();
        save = 1; alu(16'h8000, 1'b1, 3'b111); cycle(); idle();
        alu(16'h0000, 1'b0, 3'b001); cycle(); idle();
        vectors++;
        if ({c, n, z} !== 3'b111) begin
            errors++; $display("FAIL nest_setup: got cnz=%b exp=111", {c, n, z});
        end
        for (int i = 0; i < 4; i++) begin
            restore = 1; cycle(); idle();
            vectors++;
            if ({c, n, z} !== exp_cnz[i] || act_vec() !== exp_vec()) begin
                errors++; $display("FAIL nest_pop[%0d]: got cnz=%b exp=%b", i, {c, n, z}, exp_cnz[i]);
            end
        end
        vectors++;
        if (stack_err !== 1'b1 || stack_empty !== 1'b1) begin
            errors++; $display("FAIL underflow: got err=%b empty=%b exp 1 1", stack_err, stack_empty);
        end
    endtask

    task automatic test_overflow();
        idle(); rst = 1; cycle(); idle();
        for (int i = 0; i < 5; i++) begin
            save = 1; alu(W'($urandom), 1'($urandom), 3'b111); cycle(); idle();
            vectors++;
            if (act_vec() !== exp_vec() || stack_full !== (i >= 3) || stack_err !== (i == 4)) begin
                errors++; $display("FAIL overflow[%0d]: got %b exp %b", i, act_vec(), exp_vec());
            end
        end
        restore = 1; cycle(); idle();
        vectors++;
        if (act_vec() !== exp_vec()) begin
            errors++; $display("FAIL overflow_pop: got %b exp %b", act_vec(), exp_vec());
        end
        save = 1; restore = 1; cycle(); idle();
        restore = 1; cycle(); restore = 1; cycle(); idle();
        vectors++;
        if (act_vec() !== exp_vec() || stack_empty !== 1'b0) begin
            errors++; $display("FAIL conflict_count: got %b exp %b", act_vec(), exp_vec());
        end
    endtask

    task automatic test_stall_reset();
        idle(); rst = 1; cycle(); idle();
        alu(16'h8000, 1'b1, 3'b111); cycle(); idle();
        for (int i = 0; i < 3; i++) begin save = 1; cycle(); end
        idle(); en = 0; alu(16'h0000, 1'b0, 3'b111); save = 1;
        br_valid = 1; br_taken = 1; branch = 3'b110; setc = 1; cycle(); idle();
        vectors++;
        if (act_vec() !== exp_vec() || {z, n, c} !== 3'b011) begin
            errors++; $display("FAIL stall: got %b exp %b", act_vec(), exp_vec());
        end
        rst = 1; en = 0; save = 1; alu(16'h0000, 1'b1, 3'b111); cycle(); idle();
        vectors++;
        if (act_vec() !== 6'b000100) begin
            errors++; $display("FAIL mid_reset: got %b exp 000100", act_vec());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            rst        = ($urandom_range(0, 59) == 0);
            en         = ($urandom_range(0, 9) != 0);
            alu_valid  = 1'($urandom);
            alu_result = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            alu_carry  = 1'($urandom);
            flag_we    = 3'($urandom);
            setc       = ($urandom_range(0, 4) == 0);
            clrc       = ($urandom_range(0, 4) == 0);
            br_valid   = 1'($urandom);
            br_taken   = 1'($urandom);
            branch     = 3'($urandom);
            save       = ($urandom_range(0, 3) == 0);
            restore    = ($urandom_range(0, 3) == 0);
            cycle();
            vectors++;
            if (act_vec() !== exp_vec()) begin
                errors++; $display("FAIL random[%0d]: got %b exp %b", i, act_vec(), exp_vec());
            end
        end
        idle();
    endtask

    initial begin
        idle();
        mz = 0; mn = 0; mc = 0; merr = 0;
        test_reset();
        test_alu_flags();
        test_masked_carry();
        test_consume();
        test_nesting();
        test_overflow();
        test_stall_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
